// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed common-anode seven-segment back-end.
// Decimal values go through a one-shift-per-clock double-dabble; hex shows raw nibbles.
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] value,
  input  logic        mode_select,
  input  logic        update,
  output logic        busy,
  output logic [3:0]  digit_select,
  output logic [6:0]  seven
);

  localparam int            CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;
  localparam bit            BLANK_EN  = (BLANK_LEADING != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  // Active-low segment patterns, bit6..0 = g,f,e,d,c,b,a.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_glyph = 7'b1000000;
      4'h1:    seg_glyph = 7'b1111001;
      4'h2:    seg_glyph = 7'b0100100;
      4'h3:    seg_glyph = 7'b0110000;
      4'h4:    seg_glyph = 7'b0011001;
      4'h5:    seg_glyph = 7'b0010010;
      4'h6:    seg_glyph = 7'b0000010;
      4'h7:    seg_glyph = 7'b1111000;
      4'h8:    seg_glyph = 7'b0000000;
      4'h9:    seg_glyph = 7'b0010000;
      4'hA:    seg_glyph = 7'b0001000;
      4'hB:    seg_glyph = 7'b0000011;
      4'hC:    seg_glyph = 7'b1000110;
      4'hD:    seg_glyph = 7'b0100001;
      4'hE:    seg_glyph = 7'b0000110;
      4'hF:    seg_glyph = 7'b0001110;
      default: seg_glyph = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add-3 correction, then shift.
  function automatic logic [29:0] dd_step(input logic [29:0] sr);
    logic [29:0] adj;
    adj = sr;
    for (int k = 0; k < 4; k++) begin
      if (adj[14+4*k +: 4] >= 4'd5) begin
        adj[14+4*k +: 4] = adj[14+4*k +: 4] + 4'd3;
      end
    end
    dd_step = {adj[28:0], 1'b0};
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic [13:0]   r_shadow_val;
  logic          r_shadow_mode;
  logic          r_ovf;
  logic [29:0]   r_sr;
  logic [3:0]    r_iter;
  logic          r_pend_vld;
  logic [13:0]   r_pend_val;
  logic          r_pend_mode;
  logic [15:0]   r_dig;
  logic          r_dash;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_digit_select;
  logic [6:0]    r_seven;

  logic          w_start;
  logic          w_commit;
  logic          w_step;
  logic          w_pend_set;
  logic          w_pend_clr;
  logic          w_src_pend;
  logic [13:0]   w_start_val;
  logic          w_start_mode;
  logic          w_start_ovf;
  state_t        w_start_tgt;
  logic [3:0]    w_nib;
  logic          w_lead;
  logic          w_lz3;
  logic          w_lz2;
  logic          w_lz1;
  logic [6:0]    w_seven_nxt;
  logic [3:0]    w_sel_nxt;

  // A restart out of COMMIT prefers a same-cycle strobe over the older pending slot.
  assign w_src_pend   = (r_state == S_COMMIT) && !update && r_pend_vld;
  assign w_start_val  = w_src_pend ? r_pend_val  : value;
  assign w_start_mode = w_src_pend ? r_pend_mode : mode_select;
  assign w_start_ovf  = w_start_mode && (w_start_val > 14'd9999);
  assign w_start_tgt  = (w_start_mode && !w_start_ovf) ? S_CONVERT : S_COMMIT;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_step      = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (update) begin
          w_start     = 1'b1;
          w_state_nxt = w_start_tgt;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      S_CONVERT: begin
        w_step     = 1'b1;
        w_pend_set = update;
        if (r_iter == 4'd13) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_CONVERT;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        if (update || r_pend_vld) begin
          w_start     = 1'b1;
          w_pend_clr  = 1'b1;
          w_state_nxt = w_start_tgt;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Shadow capture, double-dabble shift register and atomic digit commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow_val  <= 14'd0;
      r_shadow_mode <= 1'b0;
      r_ovf         <= 1'b0;
      r_sr          <= 30'd0;
      r_iter        <= 4'd0;
      r_dig         <= 16'd0;
      r_dash        <= 1'b0;
    end else begin
      if (w_start) begin
        r_shadow_val  <= w_start_val;
        r_shadow_mode <= w_start_mode;
        r_ovf         <= w_start_ovf;
        r_sr          <= {16'd0, w_start_val};
        r_iter        <= 4'd0;
      end else if (w_step) begin
        r_sr   <= dd_step(r_sr);
        r_iter <= r_iter + 4'd1;
      end
      if (w_commit) begin
        r_dash <= r_ovf;
        r_dig  <= r_ovf ? 16'd0 : (r_shadow_mode ? r_sr[29:14] : {2'b00, r_shadow_val});
      end
    end
  end

  // One-deep pending slot; the newest strobe while busy wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_vld  <= 1'b0;
      r_pend_val  <= 14'd0;
      r_pend_mode <= 1'b0;
    end else if (w_pend_set) begin
      r_pend_vld  <= 1'b1;
      r_pend_val  <= value;
      r_pend_mode <= mode_select;
    end else if (w_pend_clr) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign w_lz3 = (r_dig[15:12] == 4'd0);
  assign w_lz2 = w_lz3 && (r_dig[11:8] == 4'd0);
  assign w_lz1 = w_lz2 && (r_dig[7:4] == 4'd0);

  // Glyph and anode selection for the digit currently being scanned.
  always_comb begin
    w_nib  = r_dig[{r_idx, 2'b00} +: 4];
    w_lead = 1'b0;
    case (r_idx)
      2'd3:    w_lead = w_lz3;
      2'd2:    w_lead = w_lz2;
      2'd1:    w_lead = w_lz1;
      default: w_lead = 1'b0;
    endcase
    if (r_dash) begin
      w_seven_nxt = SEG_DASH;
    end else if (BLANK_EN && w_lead) begin
      w_seven_nxt = SEG_BLANK;
    end else begin
      w_seven_nxt = seg_glyph(w_nib);
    end
    w_sel_nxt = ~(4'b0001 << r_idx);
  end

  // Refresh counter, scan index and registered pin drivers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt          <= {CW{1'b0}};
      r_idx          <= 2'd0;
      r_digit_select <= 4'b1111;
      r_seven        <= SEG_BLANK;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= {CW{1'b0}};
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
      r_digit_select <= w_sel_nxt;
      r_seven        <= w_seven_nxt;
    end
  end

  assign busy         = r_busy;
  assign digit_select = r_digit_select;
  assign seven        = r_seven;

endmodule
